// File: rtl/tt_harness_ctrl_if.sv
// Host command/response handshake bundle for tt_harness_ctrl.
interface tt_harness_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  // Host side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_arg, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  // Harness side: accepts commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/tt_harness_ctrl.sv
// Tiny Tapeout project pin driver: turns host byte commands into project
// ui/uio/ena/rst_n/clk activity and reads back uo_out/uio.
// Optional: define TT_HARNESS_CYCLE_CNT_EN to add a 16-bit tt_clk rising-edge
// counter readable through NOP arg=1 (low byte) and NOP arg=2 (high byte).
module tt_harness_ctrl #(
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned PCLK_HALF  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  tt_harness_ctrl_if.slave host,
  output logic [7:0]       tt_ui_in,
  input  logic [7:0]       tt_uo_out,
  output logic [7:0]       tt_uio_in,
  input  logic [7:0]       tt_uio_out,
  input  logic [7:0]       tt_uio_oe,
  output logic             tt_ena,
  output logic             tt_rst_n,
  output logic             tt_clk,
  output logic             busy
);

  localparam int unsigned TMR_W    = 8;
  localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] PH_LOAD  = TMR_W'(PCLK_HALF - 1);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_SET_UI   = 3'd1;
  localparam logic [2:0] OP_SET_UIO  = 3'd2;
  localparam logic [2:0] OP_RESET    = 3'd3;
  localparam logic [2:0] OP_STEP     = 3'd4;
  localparam logic [2:0] OP_READ_UO  = 3'd5;
  localparam logic [2:0] OP_READ_UIO = 3'd6;
  localparam logic [2:0] OP_SET_ENA  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_RSP
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       pulse_q, pulse_d;
  logic [7:0]       uio_drv_q, uio_drv_d;
  logic [7:0]       ui_d;
  logic             ena_d, prst_d, pclk_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_d;
  logic             accept;
`ifdef TT_HARNESS_CYCLE_CNT_EN
  logic [15:0]      cyc_cnt_q, cyc_cnt_d;
`endif

  // Bits the project drives loop back; the rest come from the host-set value.
  assign tt_uio_in = (tt_uio_oe & tt_uio_out) | (~tt_uio_oe & uio_drv_q);

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

  assign accept = host.cmd_valid && cmd_ready_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      pulse_q     <= '0;
      uio_drv_q   <= '0;
      tt_ui_in    <= '0;
      tt_ena      <= 1'b0;
      tt_rst_n    <= 1'b0;
      tt_clk      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy        <= 1'b0;
`ifdef TT_HARNESS_CYCLE_CNT_EN
      cyc_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pulse_q     <= pulse_d;
      uio_drv_q   <= uio_drv_d;
      tt_ui_in    <= ui_d;
      tt_ena      <= ena_d;
      tt_rst_n    <= prst_d;
      tt_clk      <= pclk_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy        <= busy_d;
`ifdef TT_HARNESS_CYCLE_CNT_EN
      cyc_cnt_q   <= cyc_cnt_d;
`endif
    end
  end

  // Command decode, reset hold, pulse sequencing and response handshake.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    pulse_d     = pulse_q;
    uio_drv_d   = uio_drv_q;
    ui_d        = tt_ui_in;
    ena_d       = tt_ena;
    prst_d      = tt_rst_n;
    pclk_d      = tt_clk;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef TT_HARNESS_CYCLE_CNT_EN
    cyc_cnt_d   = cyc_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (host.cmd_op)
            OP_NOP: begin
`ifdef TT_HARNESS_CYCLE_CNT_EN
              if (host.cmd_arg == 8'd1) begin
                rsp_data_d  = cyc_cnt_q[7:0];
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
              end else if (host.cmd_arg == 8'd2) begin
                rsp_data_d  = cyc_cnt_q[15:8];
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
              end
`endif
            end
            OP_SET_UI:  ui_d      = host.cmd_arg;
            OP_SET_UIO: uio_drv_d = host.cmd_arg;
            OP_RESET: begin
              prst_d  = 1'b0;
              tmr_d   = RST_LOAD;
              state_d = ST_RST_HOLD;
            end
            OP_STEP: begin
              pclk_d  = 1'b1;
              pulse_d = host.cmd_arg;
              tmr_d   = PH_LOAD;
              state_d = ST_STEP_HI;
            end
            OP_READ_UO: begin
              rsp_data_d  = tt_uo_out;
              rsp_valid_d = 1'b1;
              state_d     = ST_RSP;
            end
            OP_READ_UIO: begin
              rsp_data_d  = tt_uio_in;
              rsp_valid_d = 1'b1;
              state_d     = ST_RSP;
            end
            OP_SET_ENA: ena_d = host.cmd_arg[0];
          endcase
        end
      end
      ST_RST_HOLD: begin
        if (tmr_q == '0) begin
          prst_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_STEP_HI: begin
        if (tmr_q == '0) begin
          pclk_d  = 1'b0;
          tmr_d   = PH_LOAD;
          state_d = ST_STEP_LO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_STEP_LO: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (pulse_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          pulse_d = pulse_q - 8'd1;
          pclk_d  = 1'b1;
          tmr_d   = PH_LOAD;
          state_d = ST_STEP_HI;
        end
      end
      ST_RSP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TT_HARNESS_CYCLE_CNT_EN
    if (pclk_d && !tt_clk) cyc_cnt_d = cyc_cnt_q + 16'd1;
    if (state_q == ST_RST_HOLD && state_d == ST_IDLE) cyc_cnt_d = '0;
`endif

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_tt_harness_ctrl.sv
// Bench for tt_harness_ctrl: timeline-based reference model plus directed checks.
module tb_tt_harness_ctrl;

  localparam int PH = 2;
  localparam int RC = 8;

  localparam int K_IDLE = 0;
  localparam int K_RST  = 1;
  localparam int K_STEP = 2;
  localparam int K_RSP  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tt_ui_in, tt_uo_out, tt_uio_in;
  logic [7:0] tt_uio_out = 8'h00;
  logic [7:0] tt_uio_oe  = 8'h00;
  logic       tt_ena, tt_rst_n, tt_clk, busy;

  int errs = 0;
  int checks = 0;

  tt_harness_ctrl_if host();

  tt_harness_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host),
    .tt_ui_in   (tt_ui_in),
    .tt_uo_out  (tt_uo_out),
    .tt_uio_in  (tt_uio_in),
    .tt_uio_out (tt_uio_out),
    .tt_uio_oe  (tt_uio_oe),
    .tt_ena     (tt_ena),
    .tt_rst_n   (tt_rst_n),
    .tt_clk     (tt_clk),
    .busy       (busy)
  );

  // Stand-in project: outputs are the bitwise inverse of its inputs.
  assign tt_uo_out = ~tt_ui_in;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_kind = K_IDLE;
  int         m_t0 = 0, m_len = 0, cyc = 0;
  logic [7:0] m_ui = 0, m_drv = 0, m_rsp_data = 0;
  logic       m_ena = 0, m_prst = 0, m_clk = 0, m_rsp_valid = 0, m_ready = 0;
  logic [15:0] m_cnt = 0;

  function automatic logic [7:0] m_uio_in();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tt_uio_oe[i] ? tt_uio_out[i] : m_drv[i];
    return r;
  endfunction

  task automatic m_respond(input logic [7:0] d);
    m_kind = K_RSP;
    m_rsp_valid = 1'b1;
    m_rsp_data = d;
  endtask

  task automatic m_reset();
    m_kind = K_IDLE; m_ui = 0; m_drv = 0; m_ena = 0; m_prst = 0; m_clk = 0;
    m_rsp_valid = 0; m_rsp_data = 0; m_ready = 0; m_cnt = 0; cyc = 0;
  endtask

  task automatic m_step();
    int k;
    cyc++;
    case (m_kind)
      K_IDLE: begin
        if (host.cmd_valid && m_ready) begin
          case (host.cmd_op)
            3'd0: begin
`ifdef TT_HARNESS_CYCLE_CNT_EN
              if (host.cmd_arg == 8'd1) m_respond(m_cnt[7:0]);
              else if (host.cmd_arg == 8'd2) m_respond(m_cnt[15:8]);
`endif
            end
            3'd1: m_ui = host.cmd_arg;
            3'd2: m_drv = host.cmd_arg;
            3'd3: begin m_kind = K_RST; m_t0 = cyc; m_len = RC; m_prst = 1'b0; end
            3'd4: begin
              m_kind = K_STEP; m_t0 = cyc;
              m_len = (int'(host.cmd_arg) + 1) * 2 * PH;
              m_clk = 1'b1;
              m_cnt = m_cnt + 16'(int'(host.cmd_arg) + 1);
            end
            3'd5: m_respond(~m_ui);
            3'd6: m_respond(m_uio_in());
            3'd7: m_ena = host.cmd_arg[0];
            default: ;
          endcase
        end
      end
      K_RSP: begin
        if (host.rsp_ready) begin m_kind = K_IDLE; m_rsp_valid = 1'b0; end
      end
      default: begin
        k = cyc - m_t0;
        if (k >= m_len) begin
          if (m_kind == K_RST) begin m_prst = 1'b1; m_cnt = 0; end
          m_kind = K_IDLE;
          m_clk = 1'b0;
        end else if (m_kind == K_STEP) begin
          m_clk = ((k % (2 * PH)) < PH);
        end
      end
    endcase
    m_ready = (m_kind == K_IDLE);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("cmd_ready", 32'(host.cmd_ready), 32'(m_ready));
    chk("busy",      32'(busy),           32'(m_kind != K_IDLE));
    chk("rsp_valid", 32'(host.rsp_valid), 32'(m_rsp_valid));
    chk("rsp_data",  32'(host.rsp_data),  32'(m_rsp_data));
    chk("tt_ui_in",  32'(tt_ui_in),       32'(m_ui));
    chk("tt_uio_in", 32'(tt_uio_in),      32'(m_uio_in()));
    chk("tt_ena",    32'(tt_ena),         32'(m_ena));
    chk("tt_rst_n",  32'(tt_rst_n),       32'(m_prst));
    chk("tt_clk",    32'(tt_clk),         32'(m_clk));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    int n = 0;
    while (host.cmd_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("send_timeout", 32'(n), 32'd0);
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_arg   = arg;
    @(negedge clk);
    host.cmd_valid = 1'b0;
  endtask

  task automatic run_busy(output int nb, output int nh, output int nl);
    nb = 0; nh = 0; nl = 0;
    while (busy === 1'b1 && nb < 5000) begin
      nb++;
      if (tt_clk === 1'b1) nh++;
      if (tt_rst_n === 1'b0) nl++;
      @(negedge clk);
    end
    if (nb >= 5000) chk("busy_timeout", 32'(nb), 32'd0);
  endtask

  int nb, nh, nl;

  initial begin
    host.cmd_valid = 1'b0;
    host.cmd_op    = 3'd0;
    host.cmd_arg   = 8'd0;
    host.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(host.cmd_ready), 32'd1);
    chk("rst_tt_rst_n",  32'(tt_rst_n), 32'd0);
    chk("rst_tt_clk",    32'(tt_clk),   32'd0);
    chk("rst_tt_ui_in",  32'(tt_ui_in), 32'd0);
    chk("rst_tt_ena",    32'(tt_ena),   32'd0);

    // STEP while project is still held in reset
    send(3'd4, 8'd1);
    run_busy(nb, nh, nl);
    chk("step1_busy", 32'(nb), 32'd8);
    chk("step1_high", 32'(nh), 32'd4);

    // First RESET
    send(3'd3, 8'd0);
    run_busy(nb, nh, nl);
    chk("reset_busy", 32'(nb), 32'd8);
    chk("reset_low",  32'(nl), 32'd8);
    chk("reset_done", 32'(tt_rst_n), 32'd1);

    // RESET again with project already out of reset
    send(3'd7, 8'd1);
    send(3'd3, 8'd0);
    run_busy(nb, nh, nl);
    chk("reset2_low", 32'(nl), 32'd8);
    chk("reset2_ena", 32'(tt_ena), 32'd1);

    // READ_UO held off by rsp_ready
    send(3'd1, 8'hA5);
    host.rsp_ready = 1'b0;
    send(3'd5, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(host.rsp_valid), 32'd1);
      chk("hold_data",  32'(host.rsp_data),  32'h5A);
      chk("hold_ready", 32'(host.cmd_ready), 32'd0);
      @(negedge clk);
    end
    host.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_done_valid", 32'(host.rsp_valid), 32'd0);
    chk("rsp_done_busy",  32'(busy), 32'd0);

    // READ_UIO with mixed direction bits
    tt_uio_oe  = 8'hF0;
    tt_uio_out = 8'h30;
    send(3'd2, 8'h0C);
    chk("uio_in", 32'(tt_uio_in), 32'h3C);
    send(3'd6, 8'd0);
    chk("read_uio_valid", 32'(host.rsp_valid), 32'd1);
    chk("read_uio_data",  32'(host.rsp_data),  32'h3C);
    @(negedge clk);

    // STEP boundaries
    send(3'd4, 8'd0);
    chk("step0_first_high", 32'(tt_clk), 32'd1);
    run_busy(nb, nh, nl);
    chk("step0_busy", 32'(nb), 32'd4);
    chk("step0_high", 32'(nh), 32'd2);
    send(3'd4, 8'd255);
    run_busy(nb, nh, nl);
    chk("step255_busy", 32'(nb), 32'd1024);
    chk("step255_high", 32'(nh), 32'd512);
    chk("step255_clk_end", 32'(tt_clk), 32'd0);

    // Cycle counter readout
    send(3'd3, 8'd0);
    run_busy(nb, nh, nl);
    send(3'd4, 8'd9);
    run_busy(nb, nh, nl);
    chk("step9_busy", 32'(nb), 32'd40);
    send(3'd0, 8'd1);
`ifdef TT_HARNESS_CYCLE_CNT_EN
    chk("cnt_lo_valid", 32'(host.rsp_valid), 32'd1);
    chk("cnt_lo",       32'(host.rsp_data),  32'h0A);
    @(negedge clk);
    send(3'd0, 8'd2);
    chk("cnt_hi_valid", 32'(host.rsp_valid), 32'd1);
    chk("cnt_hi",       32'(host.rsp_data),  32'h00);
    @(negedge clk);
    send(3'd0, 8'd3);
    chk("nop3_valid", 32'(host.rsp_valid), 32'd0);
`else
    chk("nop1_valid", 32'(host.rsp_valid), 32'd0);
    chk("nop1_busy",  32'(busy), 32'd0);
`endif

    // Harness reset in the middle of pulse 37 of STEP 100
    send(3'd1, 8'h77);
    send(3'd4, 8'd100);
    repeat (145) @(negedge clk);
    chk("mid_clk_high", 32'(tt_clk), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_clk",   32'(tt_clk),   32'd0);
    chk("abort_rst_n", 32'(tt_rst_n), 32'd0);
    chk("abort_ena",   32'(tt_ena),   32'd0);
    chk("abort_ui",    32'(tt_ui_in), 32'd0);
    chk("abort_busy",  32'(busy),     32'd0);
    chk("abort_valid", 32'(host.rsp_valid), 32'd0);
    chk("abort_uio",   32'(tt_uio_in), 32'h30);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_ready", 32'(host.cmd_ready), 32'd1);
    send(3'd1, 8'h11);
    chk("post_abort_ui", 32'(tt_ui_in), 32'h11);
    chk("post_abort_rst_n", 32'(tt_rst_n), 32'd0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
